// File: rtl/gfx_clip_zpipe_if.sv
`default_nettype none
// ============================================================================
// Module   : gfx_clip_zpipe_if
// Purpose  : Z-buffer read/write memory port of the clip/depth stage.
// Revision : 1.0 - initial release
// ============================================================================
interface gfx_clip_zpipe_if #(
    parameter int MDW = 256
);
    logic             z_request_o;
    logic [31:0]      z_addr_o;
    logic [MDW-1:0]   z_data_i;
    logic             z_ack_i;
    logic             wbm_busy_i;
    logic             zw_request_o;
    logic [31:0]      zw_addr_o;
    logic [MDW-1:0]   zw_data_o;
    logic [MDW/8-1:0] zw_sel_o;
    logic             zw_ack_i;

    modport master (
        output z_request_o, z_addr_o,
        input  z_data_i, z_ack_i, wbm_busy_i,
        output zw_request_o, zw_addr_o, zw_data_o, zw_sel_o,
        input  zw_ack_i
    );

    modport slave (
        input  z_request_o, z_addr_o,
        output z_data_i, z_ack_i, wbm_busy_i,
        input  zw_request_o, zw_addr_o, zw_data_o, zw_sel_o,
        output zw_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/gfx_clip_zpipe.sv
`default_nettype none
// ============================================================================
// Module   : gfx_clip_zpipe
// Purpose  : Target/scissor discard, depth test with optional Z write-back.
// Revision : 1.0 - initial release
// ============================================================================
module gfx_clip_zpipe #(
    parameter int point_width = 16,
    parameter int ZW          = 16,
    parameter int MDW         = 256,
    parameter int ATTR_W      = 96
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_ni,
    input  wire logic                   clipping_enable_i,
    input  wire logic                   zbuffer_enable_i,
    input  wire logic                   zwrite_enable_i,
    input  wire logic [2:0]             zfunc_i,
    input  wire logic [31:0]            zbuffer_base_i,
    input  wire logic [point_width-1:0] target_size_x_i,
    input  wire logic [point_width-1:0] target_x0_i,
    input  wire logic [point_width-1:0] target_y0_i,
    input  wire logic [point_width-1:0] target_x1_i,
    input  wire logic [point_width-1:0] target_y1_i,
    input  wire logic [point_width-1:0] clip_x0_i,
    input  wire logic [point_width-1:0] clip_y0_i,
    input  wire logic [point_width-1:0] clip_x1_i,
    input  wire logic [point_width-1:0] clip_y1_i,
    input  wire logic [point_width-1:0] pixel_x_i,
    input  wire logic [point_width-1:0] pixel_y_i,
    input  wire logic [ZW-1:0]          pixel_z_i,
    input  wire logic [ATTR_W-1:0]      attr_i,
    input  wire logic                   ztest_i,
    input  wire logic                   write_i,
    output logic                        ack_o,
    gfx_clip_zpipe_if.master            mem,
    output logic [point_width-1:0]      pixel_x_o,
    output logic [point_width-1:0]      pixel_y_o,
    output logic [ZW-1:0]               pixel_z_o,
    output logic [ATTR_W-1:0]           attr_o,
    output logic                        write_o,
    input  wire logic                   ack_i,
    output logic [31:0]                 discard_count_o
);
    localparam int c_ZB  = ZW / 8;
    localparam int c_MB  = MDW / 8;
    localparam int c_NL  = MDW / ZW;
    localparam int c_ZSH = $clog2(c_ZB);
    localparam int c_AL  = $clog2(c_MB);
    localparam int c_LW  = (c_NL > 1) ? $clog2(c_NL) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_ZREAD  = 3'd2,
        S_ZWRITE = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t                 r_state_q, w_state_d;
    logic [point_width-1:0] r_x_q, w_x_d, r_y_q, w_y_d;
    logic [ZW-1:0]          r_z_q, w_z_d;
    logic [ATTR_W-1:0]      r_attr_q, w_attr_d;
    logic [31:0]            r_zaddr_q, w_zaddr_d;
    logic [c_LW-1:0]        r_lane_q, w_lane_d;
    logic                   r_zreq_q, w_zreq_d;
    logic                   r_zwreq_q, w_zwreq_d;
    logic                   r_ack_q, w_ack_d;
    logic [31:0]            r_discard_q, w_discard_d;

    logic                   w_discard, w_dz, w_pass, w_cnt_inc;
    logic [31:0]            w_lin, w_byte;
    logic signed [ZW-1:0]   w_zpix, w_zmem;
    logic [c_MB-1:0]        w_sel_base, w_lane_sel;

    // Half-open rectangle test; an empty rect rejects every coordinate.
    function automatic logic f_outside(input logic [point_width-1:0] x, y, x0, y0, x1, y1);
        return (x < x0) || (x >= x1) || (y < y0) || (y >= y1);
    endfunction

    assign w_discard = f_outside(pixel_x_i, pixel_y_i, target_x0_i, target_y0_i, target_x1_i, target_y1_i)
                     || (clipping_enable_i
                         && f_outside(pixel_x_i, pixel_y_i, clip_x0_i, clip_y0_i, clip_x1_i, clip_y1_i));
    assign w_dz      = zbuffer_enable_i & ztest_i;

    assign w_lin  = 32'(r_y_q) * 32'(target_size_x_i) + 32'(r_x_q);
    assign w_byte = zbuffer_base_i + (w_lin << c_ZSH);

    assign w_zpix = $signed(r_z_q);
    assign w_zmem = $signed(mem.z_data_i[r_lane_q*ZW +: ZW]);

    always_comb begin
        w_pass = 1'b0;
        case (zfunc_i)
            3'd0:    w_pass = 1'b0;
            3'd1:    w_pass = (w_zpix <  w_zmem);
            3'd2:    w_pass = (w_zpix == w_zmem);
            3'd3:    w_pass = (w_zpix <= w_zmem);
            3'd4:    w_pass = (w_zpix >  w_zmem);
            3'd5:    w_pass = (w_zpix != w_zmem);
            3'd6:    w_pass = (w_zpix >= w_zmem);
            default: w_pass = 1'b1;
        endcase
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_x_d       = r_x_q;
        w_y_d       = r_y_q;
        w_z_d       = r_z_q;
        w_attr_d    = r_attr_q;
        w_zaddr_d   = r_zaddr_q;
        w_lane_d    = r_lane_q;
        w_zreq_d    = r_zreq_q;
        w_zwreq_d   = r_zwreq_q;
        w_ack_d     = 1'b0;
        w_cnt_inc   = 1'b0;
        w_discard_d = r_discard_q;
        case (r_state_q)
            S_IDLE: begin
                // write_i is still high while our ack pulse is out; do not re-accept it.
                if (write_i && !r_ack_q) begin
                    if (w_discard) begin
                        w_ack_d   = 1'b1;
                        w_cnt_inc = 1'b1;
                    end else begin
                        w_x_d     = pixel_x_i;
                        w_y_d     = pixel_y_i;
                        w_z_d     = pixel_z_i;
                        w_attr_d  = attr_i;
                        w_state_d = w_dz ? S_ADDR : S_OUT;
                    end
                end
            end
            S_ADDR: begin
                w_zaddr_d = w_byte & ~32'(c_MB - 1);
                w_lane_d  = c_LW'(w_byte[c_AL-1:0] >> c_ZSH);
                w_state_d = S_ZREAD;
            end
            S_ZREAD: begin
                if (!r_zreq_q) begin
                    w_zreq_d = !mem.wbm_busy_i;
                end else if (mem.z_ack_i) begin
                    w_zreq_d = 1'b0;
                    if (!w_pass) begin
                        w_ack_d   = 1'b1;
                        w_cnt_inc = 1'b1;
                        w_state_d = S_IDLE;
                    end else if (zwrite_enable_i) begin
                        w_zwreq_d = 1'b1;
                        w_state_d = S_ZWRITE;
                    end else begin
                        w_state_d = S_OUT;
                    end
                end
            end
            S_ZWRITE: begin
                if (mem.zw_ack_i) begin
                    w_zwreq_d = 1'b0;
                    w_state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (ack_i) begin
                    w_ack_d   = 1'b1;
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
        if (w_cnt_inc && (r_discard_q != 32'hFFFF_FFFF)) begin
            w_discard_d = r_discard_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q   <= S_IDLE;
            r_x_q       <= '0;
            r_y_q       <= '0;
            r_z_q       <= '0;
            r_attr_q    <= '0;
            r_zaddr_q   <= '0;
            r_lane_q    <= '0;
            r_zreq_q    <= 1'b0;
            r_zwreq_q   <= 1'b0;
            r_ack_q     <= 1'b0;
            r_discard_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_x_q       <= w_x_d;
            r_y_q       <= w_y_d;
            r_z_q       <= w_z_d;
            r_attr_q    <= w_attr_d;
            r_zaddr_q   <= w_zaddr_d;
            r_lane_q    <= w_lane_d;
            r_zreq_q    <= w_zreq_d;
            r_zwreq_q   <= w_zwreq_d;
            r_ack_q     <= w_ack_d;
            r_discard_q <= w_discard_d;
        end
    end

    assign w_sel_base = c_MB'({c_ZB{1'b1}});
    assign w_lane_sel = w_sel_base << (r_lane_q * c_ZB);

    assign mem.z_request_o  = r_zreq_q;
    assign mem.z_addr_o     = r_zaddr_q;
    assign mem.zw_request_o = r_zwreq_q;
    assign mem.zw_addr_o    = r_zaddr_q;
    assign mem.zw_data_o    = {c_NL{r_z_q}};
    assign mem.zw_sel_o     = r_zwreq_q ? w_lane_sel : '0;

    assign ack_o           = r_ack_q;
    assign write_o         = (r_state_q == S_OUT);
    assign pixel_x_o       = r_x_q;
    assign pixel_y_o       = r_y_q;
    assign pixel_z_o       = r_z_q;
    assign attr_o          = r_attr_q;
    assign discard_count_o = r_discard_q;
endmodule
`default_nettype wire
